// File: rtl/ps2_key_ctrl.sv
// PS/2 key-state controller: drains driver FIFO, parses E0/F0
// prefixes, tracks held game keys, emits prioritised move state.
// Ports: clk, rst (async high); ready/data/overflow from driver,
// rdn read strobe to driver; move_state, key_event, last_code, held.
module ps2_key_ctrl #(
  parameter int           TW             = 20,
  parameter logic [TW-1:0] PREFIX_TIMEOUT = 20'd500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic [7:0] data,
  input  logic       overflow,
  output logic       rdn,
  output logic [3:0] move_state,
  output logic       key_event,
  output logic [7:0] last_code,
  output logic [4:0] held
);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SETTLE,
    DECODE,
    FLUSH
  } state_t;

  localparam logic [TW-1:0] TMAX = PREFIX_TIMEOUT - TW'(1);

  state_t        state, state_nxt;
  logic [7:0]    byte_r;
  logic          ext, ext_nxt;
  logic          brk, brk_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic [4:0]    held_nxt;
  logic [4:0]    key_mask;
  logic [2:0]    dir;
  logic          rdn_c;

  // held/mask bit order: {jump,down,right,left,up}
  always_comb begin
    key_mask = 5'b00000;
    unique case (1'b1)
      (!ext && byte_r == 8'h1D): key_mask = 5'b00001;
      ( ext && byte_r == 8'h75): key_mask = 5'b00001;
      (!ext && byte_r == 8'h1C): key_mask = 5'b00010;
      ( ext && byte_r == 8'h6B): key_mask = 5'b00010;
      (!ext && byte_r == 8'h23): key_mask = 5'b00100;
      ( ext && byte_r == 8'h74): key_mask = 5'b00100;
      (!ext && byte_r == 8'h1B): key_mask = 5'b01000;
      ( ext && byte_r == 8'h72): key_mask = 5'b01000;
      (!ext && byte_r == 8'h29): key_mask = 5'b10000;
      default:                   key_mask = 5'b00000;
    endcase
  end

  always_comb begin
    state_nxt = state;
    held_nxt  = held;
    ext_nxt   = ext;
    brk_nxt   = brk;
    cnt_nxt   = cnt;
    rdn_c     = 1'b1;
    unique case (state)
      IDLE: begin
        if (overflow)
          state_nxt = FLUSH;
        else if (ready)
          state_nxt = CAPTURE;
        if (ext || brk) begin
          if (cnt == TMAX) begin
            ext_nxt = 1'b0;
            brk_nxt = 1'b0;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + TW'(1);
          end
        end else begin
          cnt_nxt = '0;
        end
      end
      CAPTURE: begin
        rdn_c     = 1'b0;
        state_nxt = SETTLE;
      end
      SETTLE: begin
        state_nxt = DECODE;
      end
      DECODE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
        if (byte_r == 8'hE0) begin
          ext_nxt = 1'b1;
        end else if (byte_r == 8'hF0) begin
          brk_nxt = 1'b1;
        end else begin
          if (brk)
            held_nxt = held & ~key_mask;
          else
            held_nxt = held | key_mask;
          ext_nxt = 1'b0;
          brk_nxt = 1'b0;
        end
      end
      FLUSH: begin
        held_nxt = 5'b00000;
        ext_nxt  = 1'b0;
        brk_nxt  = 1'b0;
        cnt_nxt  = '0;
        rdn_c    = !ready;
        if (!ready && !overflow)
          state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Fixed priority up > down > left > right
  always_comb begin
    if (held_nxt[0])
      dir = 3'b001;
    else if (held_nxt[3])
      dir = 3'b100;
    else if (held_nxt[1])
      dir = 3'b010;
    else if (held_nxt[2])
      dir = 3'b011;
    else
      dir = 3'b000;
  end

  assign rdn = rdn_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_r     <= 8'h00;
      ext        <= 1'b0;
      brk        <= 1'b0;
      cnt        <= '0;
      held       <= 5'b00000;
      move_state <= 4'b0000;
      key_event  <= 1'b0;
      last_code  <= 8'h00;
    end else begin
      state      <= state_nxt;
      ext        <= ext_nxt;
      brk        <= brk_nxt;
      cnt        <= cnt_nxt;
      held       <= held_nxt;
      move_state <= {held_nxt[4], dir};
      key_event  <= 1'b0;
      if (state == CAPTURE)
        byte_r <= data;
      if (state == DECODE && held_nxt != held) begin
        key_event <= 1'b1;
        last_code <= byte_r;
      end
    end
  end

endmodule
